uart_tx_arbiter: RTL
====================

// Module: uart_tx_arbiter
//
// PURPOSE
// - Shares one uart_tx transmitter between NUM_REQ byte-stream requesters.
// - Round-robin arbitration is done per packet. A packet is one or more bytes ending
//   with req_last. The grant is held for the whole packet.
// - Sequences uart_tx: pulses uart_tx_en, then tracks uart_tx_busy rising and falling
//   before it accepts the next byte.
//
// PARAMETERS
// - NUM_REQ         4          number of requesters (>=1)
// - ID_W            2          width of grant_id (= clog2(NUM_REQ), min 1)
// - TIMEOUT_CYCLES  1_000_000  HOLD idle limit in clk cycles (only with UART_ARB_TIMEOUT_EN)
//
// PORTS
// - clk           in   1          system clock
// - resetn        in   1          asynchronous active-low reset
// - req_valid     in   NUM_REQ    requester i has a byte on req_data[8i+7:8i]
// - req_data      in   8*NUM_REQ  packed request bytes
// - req_last      in   NUM_REQ    byte is the final byte of its packet
// - req_ready     out  NUM_REQ    byte accepted when req_valid[i] & req_ready[i] (comb.)
// - grant_active  out  1          a packet owner exists (states other than IDLE)
// - grant_id      out  ID_W       current or most recent owner index
// - arb_timeout   out  1          1-cycle pulse: locked grant dropped by watchdog
// - uart_tx_en    out  1          to uart_tx: start send (1-cycle pulse)
// - uart_tx_data  out  8          to uart_tx: byte to send
// - uart_tx_busy  in   1          from uart_tx: transmitter busy
//
// BEHAVIOUR
// - Reset values: state=IDLE, uart_tx_en=0, uart_tx_data=0, grant_active=0,
//   grant_id=0, arb_timeout=0, rr_ptr=0 (requester 0 searched first).
// - States: IDLE, ISSUE, WAIT_START, WAIT_DONE, HOLD.
// - IDLE:
//   - winner = first i with req_valid[i], searching from rr_ptr upward and wrapping
//     modulo NUM_REQ.
//   - req_ready[winner]=1 only when uart_tx_busy=0.
//   - On accept: latch byte and last flag, owner=winner, grant_id=winner, grant_active=1,
//     go to ISSUE.
// - ISSUE: uart_tx_en=1 for exactly one cycle with uart_tx_data=latched byte, then go to
//   WAIT_START.
// - WAIT_START: wait for uart_tx_busy=1, then go to WAIT_DONE.
// - WAIT_DONE: wait for uart_tx_busy=0.
//   - If latched last=1: go to IDLE, grant_active=0, rr_ptr=(owner+1) mod NUM_REQ.
//   - Otherwise: go to HOLD.
// - HOLD: req_ready[owner]=1 and all other req_ready=0. An accept loads the byte and
//   goes to ISSUE.
// - req_ready is 0 in ISSUE, WAIT_START and WAIT_DONE. There is at most one accept per
//   byte frame.
// - Latency: accept at cycle t, uart_tx_en at t+1, uart_tx_busy seen high at t+2.
// - Non-owner requests during a packet are held off. Their req_valid must stay high; it
//   is never dropped by the arbiter.
// - Simultaneous requests: round-robin order only. Two packets never interleave on the line.
// - Deassertion of req_valid before accept: no transfer and no state change.
// - NUM_REQ=1: rr_ptr stays 0 and grant_id stays 0.
// - Reset mid-operation: asynchronous return to IDLE. uart_tx_en drops immediately and
//   the partial packet is discarded.
//
// CONFIGURATION
// - UART_ARB_TIMEOUT_EN defined:
//   - A counter runs in HOLD while req_valid[owner]=0 and clears on every owner accept.
//   - At TIMEOUT_CYCLES consecutive idle cycles: go to IDLE, pulse arb_timeout for 1 cycle,
//     set rr_ptr=(owner+1) mod NUM_REQ.
// - UART_ARB_TIMEOUT_EN undefined: no counter, arb_timeout tied 0, HOLD waits indefinitely.
//
// TESTING (uart_tx with CLK_HZ=100e6, BIT_RATE=10e6; TIMEOUT_CYCLES=50)
// - Single byte: req_valid=4'b0001, data 0x55, last=1 -> uart_tx_en pulses at t+1,
//   txd frame shows 0x55 LSB first, then grant_active=0 and rr_ptr=1.
// - Contention: req_valid=4'b1111, all packets 1 byte -> grants in order 0,1,2,3,0.
//   Bytes never overlap.
// - Packet lock: req0 sends 3 bytes A1,A2,A3 (last on A3) while req2 is valid -> line
//   carries A1 A2 A3 then req2's byte. req_ready[2]=0 throughout.
// - Backpressure: req_valid held high during a frame -> exactly one accept per frame.
//   uart_tx_en is never asserted while uart_tx_busy=1.
// - Reset mid-frame: resetn low in WAIT_DONE -> all outputs at reset values in the same
//   cycle. After release, req1 is granted normally.
// - Timeout (macro on): req3 sends 1 non-last byte, then req_valid[3]=0 for 50 cycles ->
//   arb_timeout pulses once and a waiting req0 is granted next. With macro off, HOLD
//   persists.

Source files
------------

// File: rtl/uart_tx_arbiter_if.sv
// Handshake bundle shared by the byte requesters, the arbiter and the uart_tx transmitter.
// Latency: none, wires only.
// Backpressure: req_ready per lane, uart_tx_busy from the transmitter.
//
// Ports: req_valid/req_data/req_last/req_ready (per-requester byte stream, 8 bits per lane),
//        grant_active/grant_id/arb_timeout (arbitration status),
//        uart_tx_en/uart_tx_data/uart_tx_busy (transmitter side).
// The arbiter takes the slave view; requesters plus transmitter take the master view.
interface uart_tx_arbiter_if #(
   parameter int NUM_REQ = 4,
   parameter int ID_W    = 2
);
   logic [NUM_REQ-1:0]   req_valid;
   logic [8*NUM_REQ-1:0] req_data;
   logic [NUM_REQ-1:0]   req_last;
   logic [NUM_REQ-1:0]   req_ready;
   logic                 grant_active;
   logic [ID_W-1:0]      grant_id;
   logic                 arb_timeout;
   logic                 uart_tx_en;
   logic [7:0]           uart_tx_data;
   logic                 uart_tx_busy;

   modport slave (
      input  req_valid, req_data, req_last, uart_tx_busy,
      output req_ready, grant_active, grant_id, arb_timeout, uart_tx_en, uart_tx_data
   );

   modport master (
      output req_valid, req_data, req_last, uart_tx_busy,
      input  req_ready, grant_active, grant_id, arb_timeout, uart_tx_en, uart_tx_data
   );
endinterface

// File: rtl/uart_tx_arbiter.sv
// Round-robin, packet-locked sharing of one uart_tx among NUM_REQ byte requesters.
// Latency: accept at t, uart_tx_en at t+1, next accept only after uart_tx_busy rises and falls.
// Backpressure: req_ready is combinational; only one lane is ready, and only when the line is free.
//
// Ports: clk, resetn (async active-low), bus (uart_tx_arbiter_if.slave: requester lanes,
//        grant status, uart_tx_en/uart_tx_data out, uart_tx_busy in).
// Optional macro UART_ARB_TIMEOUT_EN: HOLD watchdog that drops a silent packet owner after
// TIMEOUT_CYCLES consecutive idle cycles and pulses arb_timeout.
module uart_tx_arbiter #(
   parameter int NUM_REQ        = 4,
   parameter int ID_W           = 2,
   parameter int TIMEOUT_CYCLES = 1_000_000
) (
   input logic              clk,
   input logic              resetn,
   uart_tx_arbiter_if.slave bus
);
   localparam logic [2:0] ST_IDLE       = 3'd0;
   localparam logic [2:0] ST_ISSUE      = 3'd1;
   localparam logic [2:0] ST_WAIT_START = 3'd2;
   localparam logic [2:0] ST_WAIT_DONE  = 3'd3;
   localparam logic [2:0] ST_HOLD       = 3'd4;

   logic [2:0]         state;
   logic [ID_W-1:0]    owner;
   logic [ID_W-1:0]    rr_ptr;
   logic [ID_W-1:0]    cand;
   logic [ID_W-1:0]    winner;
   logic [ID_W-1:0]    sel_id;
   logic [ID_W-1:0]    next_ptr;
   logic               found;
   logic               accept;
   logic               timeout_now;
   logic [NUM_REQ-1:0] ready;
   logic [7:0]         sel_byte;
   logic               sel_last;
   logic [7:0]         byte_q;
   logic               last_q;

   // First valid requester at or after rr_ptr, wrapping.
   always_comb begin
      found  = 1'b0;
      winner = '0;
      cand   = '0;
      for (int k = 0; k < NUM_REQ; k++) begin
         cand = ID_W'((int'(rr_ptr) + k) % NUM_REQ);
         if (!found && bus.req_valid[cand]) begin
            found  = 1'b1;
            winner = cand;
         end
      end
   end

   // In HOLD the packet owner keeps the grant; everybody else waits.
   always_comb begin
      ready = '0;
      case (state)
         ST_IDLE: if (found && !bus.uart_tx_busy) ready[winner] = 1'b1;
         ST_HOLD: ready[owner] = 1'b1;
         default: ;
      endcase
   end

   assign sel_id   = (state == ST_HOLD) ? owner : winner;
   assign accept   = |(bus.req_valid & ready);
   assign next_ptr = ID_W'((int'(owner) + 1) % NUM_REQ);

   always_comb begin
      sel_byte = '0;
      sel_last = 1'b0;
      for (int i = 0; i < NUM_REQ; i++) begin
         if (sel_id == ID_W'(i)) begin
            sel_byte = bus.req_data[8*i +: 8];
            sel_last = bus.req_last[i];
         end
      end
   end

`ifdef UART_ARB_TIMEOUT_EN
   logic [31:0] idle_cnt;
   logic        owner_idle;

   assign owner_idle  = (state == ST_HOLD) && !bus.req_valid[owner];
   assign timeout_now = owner_idle && (idle_cnt == 32'(TIMEOUT_CYCLES - 1));

   // Counts consecutive silent HOLD cycles; any accept or state change clears it.
   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         idle_cnt        <= '0;
         bus.arb_timeout <= 1'b0;
      end else begin
         bus.arb_timeout <= timeout_now;
         if (owner_idle && !timeout_now) idle_cnt <= idle_cnt + 32'd1;
         else                            idle_cnt <= '0;
      end
   end
`else
   // Without the watchdog HOLD waits forever; the parameter is kept referenced so both
   // builds share one parameter list.
   localparam bit TIMEOUT_OK = (TIMEOUT_CYCLES >= 1);
   assign timeout_now     = 1'b0;
   assign bus.arb_timeout = 1'b0 & TIMEOUT_OK;
`endif

   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         state  <= ST_IDLE;
         owner  <= '0;
         rr_ptr <= '0;
         byte_q <= '0;
         last_q <= 1'b0;
      end else begin
         case (state)
            ST_IDLE, ST_HOLD: begin
               if (accept) begin
                  byte_q <= sel_byte;
                  last_q <= sel_last;
                  owner  <= sel_id;
                  state  <= ST_ISSUE;
               end else if (timeout_now) begin
                  rr_ptr <= next_ptr;
                  state  <= ST_IDLE;
               end
            end
            ST_ISSUE:      state <= ST_WAIT_START;
            ST_WAIT_START: if (bus.uart_tx_busy) state <= ST_WAIT_DONE;
            ST_WAIT_DONE: begin
               if (!bus.uart_tx_busy) begin
                  if (last_q) begin
                     rr_ptr <= next_ptr;
                     state  <= ST_IDLE;
                  end else begin
                     state  <= ST_HOLD;
                  end
               end
            end
            default:       state <= ST_IDLE;
         endcase
      end
   end

   // uart_tx_en decodes straight from state so an async reset removes it at once.
   assign bus.uart_tx_en   = (state == ST_ISSUE);
   assign bus.uart_tx_data = byte_q;
   assign bus.grant_active = (state != ST_IDLE);
   assign bus.grant_id     = owner;
   assign bus.req_ready    = ready;
endmodule
